ones_counter: RTL and testbench
===============================

// Module: ones_counter
// PURPOSE
//   Counts the number of '1' bits received serially on 'data', one bit per rising clock edge.
//   The running total is presented on 'count'.
//   Small datapath block used as a serial-stream statistics counter.
//   Sits directly behind the stimulus interface (clk/reset/data) and is observed by the
//   assertion/coverage monitor.
// PARAMETERS
//   WIDTH  4  width of count in bits; counts modulo 2**WIDTH (or saturates, see CONFIGURATION)
// PORTS
//   clk    input   1      single clock; all state updates on rising edge
//   reset  input   1      asynchronous, active-low reset; 0 clears the counter
//   data   input   1      serial data bit, sampled on rising clk edge
//   count  output  WIDTH  number of '1' bits sampled since the last reset
// BEHAVIOUR
//   - Reset:
//     - reset==0 forces count to 0 immediately, without waiting for a clk edge.
//     - count holds 0 for as long as reset==0; data is ignored during reset.
//   - Deassertion: first edge that can count is the first rising clk edge with reset==1.
//   - Each rising clk edge with reset==1:
//     - data==1: count <= count + 1
//     - data==0: count holds
//   - Latency: one cycle. A '1' sampled at edge N appears in count immediately after edge N.
//   - Registered output only; no combinational path from data to count.
//   - Arithmetic: unsigned, WIDTH bits.
//     - Default wrap-around: count at 2**WIDTH-1 with data==1 becomes 0 on the next edge.
//   - Reset asserted mid-stream:
//     - count clears asynchronously.
//     - Bits sampled before the reset assertion are discarded.
//   - Reset and clk edge together: reset wins; count==0.
//   - X/Z on data while reset==1: treat as don't-care for synthesis.
//     The monitor flags it as an error.
// CONFIGURATION
//   Macro ONES_COUNTER_SAT_EN
//   - Defined: count saturates at 2**WIDTH-1; further '1's leave it unchanged until reset.
//   - Undefined (default): count wraps modulo 2**WIDTH as described above.
// STRUCTURE
//   - Package ones_counter_pkg:
//     - localparam CNT_W_DEF = 4
//     - typedef logic [CNT_W_DEF-1:0] count_t
//     - function next_count(count_t c, logic d), honouring ONES_COUNTER_SAT_EN
//   - Sub-module ones_counter_dff:
//     - WIDTH-bit D register with async active-low clear.
//     - Ports: clk, reset, d, q.
//   - Top: ones_counter_dff instance plus next-count incrementer logic.
// TESTING
//   1. Assert reset=0 for 2 cycles, release; data=0 for 3 cycles -> count==0 throughout.
//   2. After reset drive data=1,1,0,1,1 -> count 1,2,2,3,4 after each successive edge.
//   3. Drive 16 consecutive '1's from 0 -> count reaches 15, then 0
//      (with ONES_COUNTER_SAT_EN: stays 15).
//   4. At count==9, drop reset between clk edges -> count==0 before next edge;
//      release, data=1 -> count==1.
//   5. 1000 random data bits with random reset pulses
//      -> count equals reference model of ones since last reset, mod 16, every cycle.
//   6. Coverage: each count value 0..15, wrap event, reset while count!=0.

Source files
------------

// File: rtl/ones_counter_pkg.sv
// Shared types and next-count arithmetic for the serial ones counter.
// Build option: define ONES_COUNTER_SAT_EN to saturate instead of wrapping.
package ones_counter_pkg;

  localparam int unsigned CNT_W_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] count_t;

  function automatic count_t next_count(count_t c, logic d);
    count_t n;
    n = c;
    if (d) begin
`ifdef ONES_COUNTER_SAT_EN
      if (c != '1) n = c + 1'b1;
`else
      n = c + 1'b1;
`endif
    end
    return n;
  endfunction

endpackage

// File: rtl/ones_counter_if.sv
// Serial data in / running count out bundle for the ones counter.
interface ones_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             data;
  logic [WIDTH-1:0] count;

  modport master (output data, input count);
  modport slave  (input data, output count);
  modport mon    (input data, input count);
endinterface

// File: rtl/ones_counter_dff.sv
// WIDTH-bit D register with asynchronous active-low clear.
module ones_counter_dff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/ones_counter.sv
// Counts '1' bits sampled serially on data; registered count, async active-low reset.
// Build option: ONES_COUNTER_SAT_EN selects saturation at 2**WIDTH-1 instead of wrap.
module ones_counter
  import ones_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  ones_counter_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // The package helper is fixed at the default width; other widths use the inline form.
  generate
    if (WIDTH == CNT_W_DEF) begin : g_pkg_next
      always_comb begin
        cnt_d = next_count(cnt_q, bus.data);
      end
    end else begin : g_gen_next
      always_comb begin
        cnt_d = cnt_q;
        if (bus.data) begin
`ifdef ONES_COUNTER_SAT_EN
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`else
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
    end
  endgenerate

  ones_counter_dff #(
    .WIDTH (WIDTH)
  ) u_dff (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  assign bus.count = cnt_q;

  data_known_a : assert property (@(posedge clk) disable iff (!reset) !$isunknown(bus.data));

endmodule

// File: tb/tb_ones_counter.sv
// Scoreboard bench for ones_counter: driver queues expected counts, monitor checks after each edge.
module tb_ones_counter;

  localparam int unsigned W = 4;

  logic clk;
  logic reset;

  ones_counter_if #(.WIDTH(W)) bus ();

  ones_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;
  int ref_cnt    = 0;
  bit seen[16];
  int wraps      = 0;
  int mid_resets = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: count=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue the count expected after the next rise.
  task automatic step(input logic r, input logic d);
    @(negedge clk);
    if (!r && reset && ref_cnt != 0) mid_resets++;
    reset    = r;
    bus.data = d;
    if (!r) ref_cnt = 0;
    else if (d) begin
`ifdef ONES_COUNTER_SAT_EN
      if (ref_cnt != 15) ref_cnt = ref_cnt + 1;
`else
      if (ref_cnt == 15) begin
        ref_cnt = 0;
        wraps++;
      end else ref_cnt = ref_cnt + 1;
`endif
    end
    exp_q.push_back(W'(ref_cnt));
  endtask

  // Monitor: one output per clock, compared against the oldest queued expectation.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seen[bus.count] = 1'b1;
        check("scoreboard", bus.count, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [4:0] pat;
    reset    = 1'b1;
    bus.data = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_initial", bus.count, '0);

    // Reset held 2 cycles, then idle zeros.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);

    // Pattern 1,1,0,1,1 -> 1,2,2,3,4.
    pat = 5'b11011;
    for (int i = 4; i >= 0; i--) step(1'b1, pat[i]);

    // Sixteen ones from zero: climbs to 15 then wraps (or holds when saturating).
    step(1'b0, 1'b0);
    repeat (16) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1);

    // Reach 9, drop reset between edges, then resume.
    step(1'b0, 1'b0);
    repeat (9) step(1'b1, 1'b1);
    @(negedge clk);
    check("pre_midcycle_reset", bus.count, 4'd9);
    #2;
    mid_resets++;
    reset = 1'b0;
    ref_cnt = 0;
    #1;
    check("midcycle_async_clear", bus.count, '0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Random bits with occasional reset pulses.
    n = 0;
    while (n < 1000) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          step(1'b0, 1'($urandom));
          n++;
        end
      end else begin
        step(1'b1, 1'($urandom_range(0, 3) != 0));
        n++;
      end
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    n = 0;
    for (int v = 0; v < 16; v++) if (seen[v]) n++;
    $display("coverage: %0d/16 count values, %0d wraps, %0d resets with nonzero count", n, wraps, mid_resets);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
